// File: rtl/ysyx_25020047_lsu_bus.sv
// rtl/ysyx_25020047_lsu_bus.sv - multi-cycle load/store unit between execute stage and a valid/ready data bus
// One access in flight; lane steering on stores, extraction and sign/zero extension on loads.
module ysyx_25020047_lsu_bus #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_wen_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [XLEN-1:0]   resp_rdata_o,
   output logic              resp_err_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic              mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic [XLEN/8-1:0] mem_wstrb_o,
   input  logic              mem_resp_valid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_resp_err_i
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t            state_q;
   logic              req_ready_q, resp_valid_q, resp_err_q, mem_req_valid_q, mem_wen_q;
   logic [XLEN-1:0]   resp_rdata_q, mem_wdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [NB-1:0]     mem_wstrb_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [OFF_W-1:0]  off_q;

   logic [OFF_W-1:0]  req_off_d;
   logic              req_bad_d;
   logic [NB-1:0]     lane_mask_d, req_strb_d;
   logic [XLEN-1:0]   req_wdata_d;

   // Request decode: alignment / size legality and store lane steering.
   always_comb begin
      req_off_d = req_addr_i[OFF_W-1:0];
      case (req_size_i)
         2'd0: begin req_bad_d = 1'b0;             lane_mask_d = NB'(8'h01); end
         2'd1: begin req_bad_d = req_addr_i[0];    lane_mask_d = NB'(8'h03); end
         2'd2: begin req_bad_d = |req_addr_i[1:0]; lane_mask_d = NB'(8'h0F); end
         default: begin
            req_bad_d   = (XLEN == 32) || (|req_addr_i[2:0]);
            lane_mask_d = NB'(8'hFF);
         end
      endcase
      req_strb_d  = lane_mask_d << req_off_d;
      req_wdata_d = req_wdata_i << {req_off_d, 3'b000};
      for (int i = 0; i < NB; i++) begin
         if (!req_strb_d[i]) req_wdata_d[8*i +: 8] = 8'h00;
      end
   end

   logic [XLEN-1:0] ld_shift_d, ld_mask_d, ld_ext_d;
   logic            ld_sign_d;

   always_comb begin
      ld_shift_d = mem_rdata_i >> {off_q, 3'b000};
      case (size_q)
         2'd0:    begin ld_mask_d = XLEN'(64'hFF);        ld_sign_d = ld_shift_d[7];      end
         2'd1:    begin ld_mask_d = XLEN'(64'hFFFF);      ld_sign_d = ld_shift_d[15];     end
         2'd2:    begin ld_mask_d = XLEN'(64'hFFFF_FFFF); ld_sign_d = ld_shift_d[31];     end
         default: begin ld_mask_d = '1;                   ld_sign_d = ld_shift_d[XLEN-1]; end
      endcase
      ld_ext_d = (ld_shift_d & ld_mask_d) | ((ld_sign_d && !unsigned_q) ? ~ld_mask_d : '0);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q         <= S_IDLE;
         req_ready_q     <= 1'b1;
         resp_valid_q    <= 1'b0;
         resp_err_q      <= 1'b0;
         resp_rdata_q    <= '0;
         mem_req_valid_q <= 1'b0;
         mem_wen_q       <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_wstrb_q     <= '0;
         size_q          <= '0;
         unsigned_q      <= 1'b0;
         off_q           <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  req_ready_q <= 1'b0;
                  size_q      <= req_size_i;
                  unsigned_q  <= req_unsigned_i;
                  off_q       <= req_off_d;
                  mem_wen_q   <= req_wen_i;
                  mem_addr_q  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  if (req_bad_d) begin
                     // Rejected without touching the bus.
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                     mem_wstrb_q  <= '0;
                     mem_wdata_q  <= '0;
                  end else begin
                     state_q         <= S_REQ;
                     mem_req_valid_q <= 1'b1;
                     mem_wstrb_q     <= req_wen_i ? req_strb_d : '0;
                     mem_wdata_q     <= req_wen_i ? req_wdata_d : '0;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready_i) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid_i) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= mem_resp_err_i;
                  resp_rdata_q <= (mem_wen_q || mem_resp_err_i) ? '0 : ld_ext_d;
               end
            end
            default: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready_o     = req_ready_q;
   assign resp_valid_o    = resp_valid_q;
   assign resp_rdata_o    = resp_rdata_q;
   assign resp_err_o      = resp_err_q;
   assign mem_req_valid_o = mem_req_valid_q;
   assign mem_wen_o       = mem_wen_q;
   assign mem_addr_o      = mem_addr_q;
   assign mem_wdata_o     = mem_wdata_q;
   assign mem_wstrb_o     = mem_wstrb_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu_bus.sv
// tb/tb_ysyx_25020047_lsu_bus.sv - scoreboard bench for the LSU, XLEN=32 and XLEN=64 instances
// Inputs are shared; sel routes req_valid to one instance and muxes its outputs for observation.
module tb_ysyx_25020047_lsu_bus;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, sel, req_valid, req_wen, req_uns, resp_ready;
   logic        mem_req_ready, mem_resp_valid, mem_resp_err;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, mem_rdata;

   logic        a_req_ready, a_resp_valid, a_resp_err, a_mreq, a_mwen;
   logic [31:0] a_rdata, a_maddr, a_mwdata;
   logic [3:0]  a_wstrb;
   logic        b_req_ready, b_resp_valid, b_resp_err, b_mreq, b_mwen;
   logic [63:0] b_rdata, b_mwdata;
   logic [31:0] b_maddr;
   logic [7:0]  b_wstrb;

   logic        o_req_ready, o_resp_valid, o_resp_err, o_mreq, o_mwen;
   logic [63:0] o_rdata, o_mwdata;
   logic [31:0] o_maddr;
   logic [7:0]  o_wstrb;

   assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
   assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
   assign o_resp_err   = sel ? b_resp_err   : a_resp_err;
   assign o_rdata      = sel ? b_rdata      : {32'h0, a_rdata};
   assign o_mreq       = sel ? b_mreq       : a_mreq;
   assign o_mwen       = sel ? b_mwen       : a_mwen;
   assign o_maddr      = sel ? b_maddr      : a_maddr;
   assign o_mwdata     = sel ? b_mwdata     : {32'h0, a_mwdata};
   assign o_wstrb      = sel ? b_wstrb      : {4'h0, a_wstrb};

   ysyx_25020047_lsu_bus #(.XLEN(32), .ADDR_W(32)) dut32 (
      .clock_i(clk), .reset_i(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(a_req_ready),
      .req_wen_i(req_wen), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata[31:0]), .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(a_rdata), .resp_err_o(a_resp_err), .mem_req_valid_o(a_mreq),
      .mem_req_ready_i(mem_req_ready), .mem_wen_o(a_mwen), .mem_addr_o(a_maddr),
      .mem_wdata_o(a_mwdata), .mem_wstrb_o(a_wstrb), .mem_resp_valid_i(mem_resp_valid),
      .mem_rdata_i(mem_rdata[31:0]), .mem_resp_err_i(mem_resp_err));

   ysyx_25020047_lsu_bus #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clock_i(clk), .reset_i(rst), .req_valid_i(req_valid & sel), .req_ready_o(b_req_ready),
      .req_wen_i(req_wen), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(b_rdata), .resp_err_o(b_resp_err), .mem_req_valid_o(b_mreq),
      .mem_req_ready_i(mem_req_ready), .mem_wen_o(b_mwen), .mem_addr_o(b_maddr),
      .mem_wdata_o(b_mwdata), .mem_wstrb_o(b_wstrb), .mem_resp_valid_i(mem_resp_valid),
      .mem_rdata_i(mem_rdata), .mem_resp_err_i(mem_resp_err));

   typedef struct {
      int          lat;
      logic        mreq;
      logic [31:0] maddr;
      logic [63:0] mwdata;
      logic [7:0]  wstrb;
      logic        mwen;
      logic [63:0] rdata;
      logic        err;
      logic        stable;
      logic        hold_ok;
      logic        done_ok;
   } obs_t;

   obs_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic obs_t blank();
      obs_t r;
      r.lat = 3; r.mreq = 1'b1; r.maddr = '0; r.mwdata = '0; r.wstrb = '0; r.mwen = 1'b0;
      r.rdata = '0; r.err = 1'b0; r.stable = 1'b1; r.hold_ok = 1'b1; r.done_ok = 1'b1;
      return r;
   endfunction

   // Byte-wise reference for load extraction.
   function automatic logic [63:0] model_load(int xlen, logic [1:0] size, bit uns,
                                              logic [31:0] addr, logic [63:0] w);
      int nb = 1 << size;
      int off = int'(addr % (xlen / 8));
      logic [63:0] v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
      if (!uns && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      if (xlen == 32) v[63:32] = '0;
      return v;
   endfunction

   // Drives one access, plays the memory, and records what the DUT showed.
   task automatic xfer(input bit s64, input bit wen, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] mrd,
                       input bit merr, input int req_stall, input int rr_stall, output obs_t o);
      int  stall = 0;
      bit  hs = 0, sent = 0;
      o = blank(); o.lat = -1; o.mreq = 1'b0; o.done_ok = 1'b0;
      sel = s64; req_wen = wen; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = 64'hA5A5_5A5A_C3C3_3C3C;
         if (o_resp_valid) begin o.lat = cyc; break; end
         if (o_mreq) begin
            if (!o.mreq) begin
               o.mreq = 1'b1; o.maddr = o_maddr; o.mwdata = o_mwdata; o.wstrb = o_wstrb; o.mwen = o_mwen;
            end else if ({o_maddr, o_mwdata, o_wstrb, o_mwen} !== {o.maddr, o.mwdata, o.wstrb, o.mwen}) begin
               o.stable = 1'b0;
            end
            if (stall < req_stall) stall++;
            else begin mem_req_ready = 1'b1; hs = 1; end
         end else if (hs && !sent) begin
            mem_resp_valid = 1'b1; mem_rdata = mrd; mem_resp_err = merr; sent = 1;
         end
         @(negedge clk);
      end
      if (o.lat >= 0) begin
         o.rdata = o_rdata; o.err = o_resp_err;
         for (int k = 0; k < rr_stall; k++) begin
            @(negedge clk);
            if (!o_resp_valid || o_req_ready || o_rdata !== o.rdata || o_resp_err !== o.err) o.hold_ok = 1'b0;
         end
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         o.done_ok = !o_resp_valid && o_req_ready;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if ({a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_mreq, b_mreq, a_mwen, b_mwen} !== 8'b1100_0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 11000000",
            {a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_mreq, b_mreq, a_mwen, b_mwen});
      end
      n_chk++;
      if ({a_rdata, b_rdata, a_maddr, b_maddr, a_wstrb, b_wstrb, a_resp_err, b_resp_err} !== '0) begin
         n_fail++; $display("FAIL reset_data: got rdata %h/%h addr %h/%h strb %h/%h expected all zero",
            a_rdata, b_rdata, a_maddr, b_maddr, a_wstrb, b_wstrb);
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      n_chk++;
      if ({a_resp_valid, b_resp_valid, a_req_ready, b_req_ready} !== 4'b0011) begin
         n_fail++; $display("FAIL reset_stale_resp: got %b expected 0011",
            {a_resp_valid, b_resp_valid, a_req_ready, b_req_ready});
      end
   endtask

   task automatic test_load_byte();
      obs_t e, o;
      e = blank(); e.maddr = 32'h8000_0000; e.rdata = 64'hFFFF_FF80;
      exp_q.push_back(e);
      e.rdata = 64'h0000_0080;
      exp_q.push_back(e);
      for (int u = 0; u < 2; u++) begin
         xfer(0, 0, 2'd0, u[0], 32'h8000_0003, '0, 64'h80FF_1234, 0, 0, 0, o);
         e = exp_q.pop_front();
         n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL lb_rdata u=%0d: got %h expected %h", u, o.rdata, e.rdata); end
         n_chk++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL lb_latency u=%0d: got %0d expected %0d", u, o.lat, e.lat); end
         n_chk++; if ({o.maddr, o.wstrb, o.mwen, o.err} !== {e.maddr, e.wstrb, e.mwen, e.err}) begin
            n_fail++; $display("FAIL lb_bus u=%0d: got addr %h strb %h wen %b err %b expected addr %h strb 0 wen 0 err 0",
               u, o.maddr, o.wstrb, o.mwen, o.err, e.maddr);
         end
      end
   endtask

   task automatic test_store_half();
      obs_t e, o;
      e = blank(); e.maddr = 32'h8000_0000; e.mwdata = 64'hBEEF_0000; e.wstrb = 8'b1100; e.mwen = 1'b1;
      exp_q.push_back(e);
      xfer(0, 1, 2'd1, 0, 32'h8000_0002, 64'hDEAD_BEEF, 64'hFFFF_FFFF, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.mwdata, o.wstrb, o.mwen} !== {e.mwdata, e.wstrb, e.mwen}) begin
         n_fail++; $display("FAIL sh_lanes: got wdata %h strb %b wen %b expected %h %b %b",
            o.mwdata, o.wstrb, o.mwen, e.mwdata, e.wstrb, e.mwen);
      end
      n_chk++; if ({o.rdata, o.err, o.done_ok} !== {e.rdata, e.err, e.done_ok}) begin
         n_fail++; $display("FAIL sh_resp: got rdata %h err %b done %b expected 0 0 1", o.rdata, o.err, o.done_ok);
      end
   endtask

   task automatic test_misaligned();
      obs_t e, o;
      e = blank(); e.lat = 1; e.mreq = 1'b0; e.err = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back(e);
      xfer(0, 0, 2'd2, 0, 32'h8000_0001, '0, 64'h1111_2222, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.lat, o.mreq, o.err, o.rdata, o.done_ok} !== {e.lat, e.mreq, e.err, e.rdata, e.done_ok}) begin
         n_fail++; $display("FAIL lw_misaligned: got lat %0d mreq %b err %b rdata %h done %b expected 1 0 1 0 1",
            o.lat, o.mreq, o.err, o.rdata, o.done_ok);
      end
      xfer(0, 1, 2'd3, 0, 32'h8000_0000, 64'h1234, '0, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.lat, o.mreq, o.err, o.rdata} !== {e.lat, e.mreq, e.err, e.rdata}) begin
         n_fail++; $display("FAIL sd_on_xlen32: got lat %0d mreq %b err %b rdata %h expected 1 0 1 0",
            o.lat, o.mreq, o.err, o.rdata);
      end
   endtask

   task automatic test_backpressure();
      obs_t e, o;
      e = blank(); e.lat = 6; e.maddr = 32'h8000_0004; e.rdata = 64'h1234_5678;
      exp_q.push_back(e);
      xfer(0, 0, 2'd2, 0, 32'h8000_0004, '0, 64'h1234_5678, 0, 3, 2, o);
      e = exp_q.pop_front();
      n_chk++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", o.lat, e.lat); end
      n_chk++; if ({o.stable, o.hold_ok, o.done_ok} !== 3'b111) begin
         n_fail++; $display("FAIL bp_hold: got stable %b resp_hold %b done %b expected 1 1 1", o.stable, o.hold_ok, o.done_ok);
      end
      n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL bp_rdata: got %h expected %h", o.rdata, e.rdata); end
      e = blank(); e.lat = 6; e.maddr = 32'h8000_0000; e.mwdata = 64'h0000_AB00; e.wstrb = 8'b0010; e.mwen = 1'b1;
      exp_q.push_back(e);
      xfer(0, 1, 2'd0, 0, 32'h8000_0001, 64'h5555_55AB, '0, 0, 3, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.lat, o.stable, o.mwdata, o.wstrb} !== {e.lat, e.stable, e.mwdata, e.wstrb}) begin
         n_fail++; $display("FAIL bp_store: got lat %0d stable %b wdata %h strb %b expected %0d 1 %h %b",
            o.lat, o.stable, o.mwdata, o.wstrb, e.lat, e.mwdata, e.wstrb);
      end
   endtask

   task automatic test_bus_error();
      obs_t e, o;
      e = blank(); e.err = 1'b1; e.maddr = 32'h8000_0008; e.mwdata = 64'h1122_3344; e.wstrb = 8'hF; e.mwen = 1'b1;
      exp_q.push_back(e);
      xfer(0, 1, 2'd2, 0, 32'h8000_0008, 64'h1122_3344, 64'hFFFF_FFFF, 1, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.err, o.rdata, o.mwdata, o.wstrb} !== {e.err, e.rdata, e.mwdata, e.wstrb}) begin
         n_fail++; $display("FAIL sw_bus_err: got err %b rdata %h wdata %h strb %h expected 1 0 %h %h",
            o.err, o.rdata, o.mwdata, o.wstrb, e.mwdata, e.wstrb);
      end
      e = blank(); e.err = 1'b1; e.maddr = 32'h8000_0010;
      exp_q.push_back(e);
      xfer(0, 0, 2'd2, 0, 32'h8000_0010, '0, 64'h8765_4321, 1, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.err, o.rdata} !== {e.err, e.rdata}) begin
         n_fail++; $display("FAIL lw_bus_err: got err %b rdata %h expected 1 0", o.err, o.rdata);
      end
   endtask

   task automatic test_xlen64();
      obs_t e, o;
      e = blank(); e.maddr = 32'h8; e.rdata = 64'h0123_4567_89AB_CDEF;
      exp_q.push_back(e);
      xfer(1, 0, 2'd3, 0, 32'h8, '0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.rdata, o.maddr, o.lat} !== {e.rdata, e.maddr, e.lat}) begin
         n_fail++; $display("FAIL ld64: got rdata %h addr %h lat %0d expected %h %h %0d", o.rdata, o.maddr, o.lat, e.rdata, e.maddr, e.lat);
      end
      e = blank(); e.maddr = 32'h8; e.rdata = 64'hFFFF_FFFF_8000_0000;
      exp_q.push_back(e);
      xfer(1, 0, 2'd2, 0, 32'hC, '0, 64'h8000_0000_1234_5678, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.rdata, o.maddr} !== {e.rdata, e.maddr}) begin
         n_fail++; $display("FAIL lw64: got rdata %h addr %h expected %h %h", o.rdata, o.maddr, e.rdata, e.maddr);
      end
      e = blank(); e.maddr = 32'h10; e.rdata = 64'hBEEF;
      exp_q.push_back(e);
      xfer(1, 0, 2'd1, 1, 32'h16, '0, 64'hBEEF_0000_0000_0000, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.rdata, o.maddr} !== {e.rdata, e.maddr}) begin
         n_fail++; $display("FAIL lhu64: got rdata %h addr %h expected %h %h", o.rdata, o.maddr, e.rdata, e.maddr);
      end
      e = blank(); e.maddr = 32'h10; e.mwdata = 64'h0000_7F00_0000_0000; e.wstrb = 8'h20; e.mwen = 1'b1;
      exp_q.push_back(e);
      xfer(1, 1, 2'd0, 0, 32'h15, 64'hFFFF_FFFF_FFFF_FF7F, '0, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.mwdata, o.wstrb, o.maddr, o.rdata} !== {e.mwdata, e.wstrb, e.maddr, e.rdata}) begin
         n_fail++; $display("FAIL sb64: got wdata %h strb %h addr %h rdata %h expected %h %h %h 0",
            o.mwdata, o.wstrb, o.maddr, o.rdata, e.mwdata, e.wstrb, e.maddr);
      end
      e = blank(); e.lat = 1; e.mreq = 1'b0; e.err = 1'b1;
      exp_q.push_back(e);
      xfer(1, 0, 2'd3, 0, 32'h4, '0, '0, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.lat, o.mreq, o.err} !== {e.lat, e.mreq, e.err}) begin
         n_fail++; $display("FAIL ld64_misaligned: got lat %0d mreq %b err %b expected 1 0 1", o.lat, o.mreq, o.err);
      end
   endtask

   task automatic test_reset_in_wait();
      bit quiet = 1;
      obs_t e, o;
      sel = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_uns = 1'b0; req_addr = 32'h8; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n_chk++; if (o_mreq !== 1'b1) begin n_fail++; $display("FAIL rstw_mreq: got %b expected 1", o_mreq); end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if ({o_req_ready, o_resp_valid, o_mreq} !== 3'b100) begin
         n_fail++; $display("FAIL rstw_idle: got ready/resp/mreq %b expected 100", {o_req_ready, o_resp_valid, o_mreq});
      end
      mem_resp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      repeat (3) begin
         if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) quiet = 0;
         @(negedge clk);
      end
      n_chk++; if (!quiet) begin n_fail++; $display("FAIL rstw_late_resp: got resp_valid after reset, expected none"); end
      e = blank(); e.maddr = 32'h8; e.rdata = 64'h0000_0000_0000_00F0;
      exp_q.push_back(e);
      xfer(1, 0, 2'd0, 1, 32'hF, '0, 64'hF000_0000_0000_0000, 0, 0, 0, o);
      e = exp_q.pop_front();
      n_chk++; if ({o.rdata, o.lat, o.done_ok} !== {e.rdata, e.lat, e.done_ok}) begin
         n_fail++; $display("FAIL rstw_recover: got rdata %h lat %0d done %b expected %h %0d 1", o.rdata, o.lat, o.done_ok, e.rdata, e.lat);
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      bit s64, uns;
      logic [1:0] size;
      logic [31:0] addr;
      logic [63:0] w;
      int xl;
      for (int n = 0; n < 16; n++) begin
         s64 = n[0];
         xl = s64 ? 64 : 32;
         size = s64 ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
         uns = 1'($urandom_range(0, 1));
         addr = $urandom & ~((32'd1 << size) - 32'd1);
         w = {$urandom, $urandom};
         e = blank(); e.maddr = addr & ~32'(xl / 8 - 1); e.rdata = model_load(xl, size, uns, addr, w);
         exp_q.push_back(e);
         xfer(s64, 0, size, uns, addr, '0, w, 0, n % 3, n % 2, o);
         e = exp_q.pop_front();
         e.lat = 3 + (n % 3);
         n_chk++; if ({o.rdata, o.maddr, o.lat, o.err, o.hold_ok, o.done_ok} !== {e.rdata, e.maddr, e.lat, e.err, e.hold_ok, e.done_ok}) begin
            n_fail++; $display("FAIL b2b_%0d x%0d size %0d uns %0d addr %h: got rdata %h addr %h lat %0d err %b hold %b done %b expected %h %h %0d 0 1 1",
               n, xl, size, uns, addr, o.rdata, o.maddr, o.lat, o.err, o.hold_ok, o.done_ok, e.rdata, e.maddr, e.lat);
         end
      end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_uns = 1'b0; resp_ready = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      req_size = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
      test_reset();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_backpressure();
      test_bus_error();
      test_xlen64();
      test_reset_in_wait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
